// File: rtl/i2c_cmd_sequencer_pkg.sv
// Shared types and constants for the I2C command sequencer: FSM state encoding,
// command layout and a saturating counter helper.
package i2c_cmd_sequencer_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int CMD_W  = 1 + ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_ACT  = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_RESP      = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_fifo.sv
// seq_cmd_fifo: DEPTH-entry register FIFO holding queued commands. A push is
// visible at the head no earlier than the following cycle (no fall-through).
module seq_cmd_fifo
    import i2c_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign count  = count_r;
    assign rdata  = mem_r[rd_ptr_r];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Storage, pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues commands, launches one I2C transaction at a time and
// returns a response per command. Optional macro I2C_SEQ_STATS_EN adds STAT_* counters.
module i2c_cmd_sequencer
    import i2c_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int IDLE_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_RNW,
    input  logic [6:0]  CMD_ADDR,
    input  logic [15:0] CMD_WDATA,
    output logic        START_STB,
    output logic        RNW,
    output logic [6:0]  I2C_ADDR,
    output logic [15:0] WR_DATA,
    input  logic        SCL,
    input  logic [15:0] RD_DATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic        RSP_RNW,
    output logic [15:0] RSP_RDATA,
    output logic        RSP_TIMEOUT,
    output logic        BUSY
`ifdef I2C_SEQ_STATS_EN
    ,
    output logic [15:0] STAT_DONE,
    output logic [15:0] STAT_TMO
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int IW = $clog2(IDLE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

    seq_state_t             state_r;
    logic [TW-1:0]          tmo_cnt_r;
    logic [IW-1:0]          idle_cnt_r;
    cmd_t                   head_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
    logic                   fifo_pop_s;
    logic                   tmo_hit_s;
    logic                   done_s;

    seq_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (CMD_VALID),
        .wdata ({CMD_RNW, CMD_ADDR, CMD_WDATA}),
        .pop   (fifo_pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign CMD_READY  = ~fifo_full_s;
    assign BUSY       = (state_r != S_IDLE) || (fifo_count_s != '0);
    assign fifo_pop_s = (state_r == S_IDLE) && !fifo_empty_s;
    assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
    assign done_s     = SCL && (idle_cnt_r == IDLE_LAST);

    // Transaction FSM with registered launch and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            tmo_cnt_r   <= {TW{1'b0}};
            idle_cnt_r  <= {IW{1'b0}};
            START_STB   <= 1'b0;
            RNW         <= 1'b0;
            I2C_ADDR    <= 7'h00;
            WR_DATA     <= 16'h0000;
            RSP_VALID   <= 1'b0;
            RSP_RNW     <= 1'b0;
            RSP_RDATA   <= 16'h0000;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            START_STB <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (!fifo_empty_s) begin
                        RNW       <= head_s.rnw;
                        I2C_ADDR  <= head_s.addr;
                        WR_DATA   <= head_s.wdata;
                        START_STB <= 1'b1;
                        state_r   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tmo_cnt_r  <= {TW{1'b0}};
                    idle_cnt_r <= {IW{1'b0}};
                    state_r    <= S_WAIT_ACT;
                end
                S_WAIT_ACT, S_WAIT_IDLE: begin
                    tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    // Timeout wins over a completion detected in the same cycle.
                    if (tmo_hit_s) begin
                        RSP_VALID   <= 1'b1;
                        RSP_RNW     <= RNW;
                        RSP_RDATA   <= 16'h0000;
                        RSP_TIMEOUT <= 1'b1;
                        state_r     <= S_RESP;
                    end else if (state_r == S_WAIT_ACT) begin
                        if (!SCL) begin
                            idle_cnt_r <= {IW{1'b0}};
                            state_r    <= S_WAIT_IDLE;
                        end
                    end else if (done_s) begin
                        RSP_VALID   <= 1'b1;
                        RSP_RNW     <= RNW;
                        RSP_RDATA   <= RNW ? RD_DATA : 16'h0000;
                        RSP_TIMEOUT <= 1'b0;
                        state_r     <= S_RESP;
                    end else if (SCL) begin
                        idle_cnt_r <= idle_cnt_r + IW'(1);
                    end else begin
                        idle_cnt_r <= {IW{1'b0}};
                    end
                end
                S_RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef I2C_SEQ_STATS_EN
    // Saturating response statistics, bumped on each response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            STAT_DONE <= 16'h0000;
            STAT_TMO  <= 16'h0000;
        end else if ((state_r == S_RESP) && RSP_READY) begin
            if (RSP_TIMEOUT) begin
                STAT_TMO <= sat_inc16(STAT_TMO);
            end else begin
                STAT_DONE <= sat_inc16(STAT_DONE);
            end
        end
    end
`endif

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a generator model and a scoreboard of
// expected launches and responses.
module tb_i2c_cmd_sequencer;
    import i2c_cmd_sequencer_pkg::*;

    typedef struct packed {
        logic        rnw;
        logic [15:0] rdata;
        logic        tmo;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_RNW;
    logic [6:0]  CMD_ADDR;
    logic [15:0] CMD_WDATA;
    logic        START_STB;
    logic        RNW;
    logic [6:0]  I2C_ADDR;
    logic [15:0] WR_DATA;
    logic        SCL;
    logic [15:0] RD_DATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic        RSP_RNW;
    logic [15:0] RSP_RDATA;
    logic        RSP_TIMEOUT;
    logic        BUSY;
`ifdef I2C_SEQ_STATS_EN
    logic [15:0] STAT_DONE;
    logic [15:0] STAT_TMO;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic scl_stuck = 1'b0;
    logic active    = 1'b0;
    cmd_t lq[$];
    rsp_t rq[$];

    assign RD_DATA = 16'h5678;

    i2c_cmd_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_RNW     (CMD_RNW),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_WDATA   (CMD_WDATA),
        .START_STB   (START_STB),
        .RNW         (RNW),
        .I2C_ADDR    (I2C_ADDR),
        .WR_DATA     (WR_DATA),
        .SCL         (SCL),
        .RD_DATA     (RD_DATA),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_RNW     (RSP_RNW),
        .RSP_RDATA   (RSP_RDATA),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .BUSY        (BUSY)
`ifdef I2C_SEQ_STATS_EN
        ,
        .STAT_DONE   (STAT_DONE),
        .STAT_TMO    (STAT_TMO)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Generator model: after each launch, 8 SCL low/high pulses, then SCL idles high.
    initial begin
        SCL = 1'b1;
        forever begin
            @(negedge clk);
            if (START_STB && !scl_stuck) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    SCL = 1'b0;
                    repeat (2) @(negedge clk);
                    SCL = 1'b1;
                    repeat (2) @(negedge clk);
                end
            end
        end
    end

    // Scoreboard monitor: launches and responses are popped and compared in order.
    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
            lq.delete();
            rq.delete();
        end else begin
            if (START_STB) begin
                check("start_no_overlap", 32'(active), 32'(0));
                active = 1'b1;
                check("start_expected", 32'(lq.size() != 0), 32'(1));
                if (lq.size() != 0) begin
                    cmd_t c;
                    c = lq.pop_front();
                    check("launch_rnw", 32'(RNW), 32'(c.rnw));
                    check("launch_addr", 32'(I2C_ADDR), 32'(c.addr));
                    check("launch_wdata", 32'(WR_DATA), 32'(c.wdata));
                end
            end
            if (RSP_VALID && RSP_READY) begin
                active = 1'b0;
                check("rsp_expected", 32'(rq.size() != 0), 32'(1));
                if (rq.size() != 0) begin
                    rsp_t r;
                    r = rq.pop_front();
                    check("rsp_rnw", 32'(RSP_RNW), 32'(r.rnw));
                    check("rsp_rdata", 32'(RSP_RDATA), 32'(r.rdata));
                    check("rsp_timeout", 32'(RSP_TIMEOUT), 32'(r.tmo));
                end
            end
        end
    end

    task automatic push_cmd(input logic rnw, input logic [6:0] addr, input logic [15:0] wd,
                            input logic exp_tmo);
        int guard = 0;
        CMD_VALID = 1'b1;
        CMD_RNW   = rnw;
        CMD_ADDR  = addr;
        CMD_WDATA = wd;
        while (!CMD_READY && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready_bound", 32'(guard < 500), 32'(1));
        @(negedge clk);
        lq.push_back(cmd_t'{rnw, addr, wd});
        rq.push_back(rsp_t'{rnw, (rnw && !exp_tmo) ? 16'h5678 : 16'h0000, exp_tmo});
    endtask

    task automatic wait_start(input string tag, input int lim);
        int n = 0;
        while (!START_STB && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(START_STB), 32'(1));
    endtask

    task automatic wait_drain(input string tag, input int lim);
        int n = 0;
        while ((lq.size() != 0 || rq.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(lq.size() + rq.size()), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          n;
        int          t0;
        int          starts;
        logic        stable;
        logic [17:0] snap;

        rst       = 1'b1;
        CMD_VALID = 1'b0;
        CMD_RNW   = 1'b0;
        CMD_ADDR  = 7'h00;
        CMD_WDATA = 16'h0000;
        RSP_READY = 1'b1;
        #5;
        check("rst_cmd_ready", 32'(CMD_READY), 32'(1));
        check("rst_start", 32'(START_STB), 32'(0));
        check("rst_rsp_valid", 32'(RSP_VALID), 32'(0));
        check("rst_busy", 32'(BUSY), 32'(0));
        check("rst_outs", 32'({RNW, I2C_ADDR, WR_DATA}), 32'(0));
        #20;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'({BUSY, START_STB, RSP_VALID, CMD_READY}), 32'(4'b0001));

        // 1: write
        push_cmd(1'b0, 7'h3D, 16'h1234, 1'b0);
        CMD_VALID = 1'b0;
        wait_drain("s1_drain", 400);

        // 2: read
        push_cmd(1'b1, 7'h3D, 16'h0000, 1'b0);
        CMD_VALID = 1'b0;
        wait_drain("s2_drain", 400);
`ifdef I2C_SEQ_STATS_EN
        check("stat_done", 32'(STAT_DONE), 32'(2));
        check("stat_tmo", 32'(STAT_TMO), 32'(0));
`endif

        // 3: fill the FIFO behind an in-flight transaction
        push_cmd(1'b0, 7'h20, 16'hA000, 1'b0);
        CMD_VALID = 1'b0;
        wait_start("s3_blocker_start", 50);
        push_cmd(1'b0, 7'h21, 16'hA001, 1'b0);
        push_cmd(1'b1, 7'h22, 16'hA002, 1'b0);
        push_cmd(1'b0, 7'h23, 16'hA003, 1'b0);
        push_cmd(1'b1, 7'h24, 16'hA004, 1'b0);
        check("s3_full_ready_low", 32'(CMD_READY), 32'(0));
        check("s3_busy", 32'(BUSY), 32'(1));
        push_cmd(1'b0, 7'h25, 16'hA005, 1'b0);
        CMD_VALID = 1'b0;
        wait_drain("s3_drain", 2000);

        // 4: timeout with SCL stuck high
        scl_stuck = 1'b1;
        push_cmd(1'b0, 7'h11, 16'hBEEF, 1'b1);
        CMD_VALID = 1'b0;
        wait_start("s4_start", 50);
        t0 = cyc;
        n  = 0;
        while (!RSP_VALID && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("s4_tmo_latency", 32'(cyc - t0), 32'(4097));
        wait_drain("s4_drain", 50);
        scl_stuck = 1'b0;

        // 5: response back-pressure
        RSP_READY = 1'b0;
        push_cmd(1'b1, 7'h5A, 16'h0001, 1'b0);
        push_cmd(1'b0, 7'h5B, 16'h0002, 1'b0);
        CMD_VALID = 1'b0;
        n = 0;
        while (!RSP_VALID && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("s5_rsp_valid", 32'(RSP_VALID), 32'(1));
        snap   = {RSP_RNW, RSP_RDATA, RSP_TIMEOUT};
        stable = 1'b1;
        starts = 0;
        repeat (100) begin
            @(negedge clk);
            if (!RSP_VALID || {RSP_RNW, RSP_RDATA, RSP_TIMEOUT} !== snap) stable = 1'b0;
            if (START_STB) starts++;
        end
        check("s5_payload_stable", 32'(stable), 32'(1));
        check("s5_no_start", 32'(starts), 32'(0));
        RSP_READY = 1'b1;
        wait_drain("s5_drain", 800);

        // 6: reset in WAIT_IDLE with two commands queued
        push_cmd(1'b0, 7'h6C, 16'hAAAA, 1'b0);
        CMD_VALID = 1'b0;
        wait_start("s6_start", 50);
        push_cmd(1'b1, 7'h6D, 16'hBBBB, 1'b0);
        push_cmd(1'b0, 7'h6E, 16'hCCCC, 1'b0);
        CMD_VALID = 1'b0;
        n = 0;
        while (SCL && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("s6_rst_outs", 32'({START_STB, RNW, I2C_ADDR, WR_DATA}), 32'(0));
        check("s6_rst_rsp", 32'({RSP_VALID, RSP_RNW, RSP_RDATA, RSP_TIMEOUT}), 32'(0));
        check("s6_rst_busy", 32'(BUSY), 32'(0));
        check("s6_rst_ready", 32'(CMD_READY), 32'(1));
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        starts = 0;
        repeat (100) begin
            @(negedge clk);
            if (START_STB) starts++;
        end
        check("s6_no_start", 32'(starts), 32'(0));
        check("s6_busy_after", 32'(BUSY), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
